arcade_input_mapper: RTL and testbench

Parametrised control-input front end for the vector-arcade cores (Battlezone, Bradley, Red Baron). Sits between `hps_io` and the game `top`. It does the following:
- captures the core-select byte and DIP-switch bytes from the ioctl stream;
- converts N players' digital and analog joysticks into registered tank-tread commands, in single-stick or dual-stick mode;
- stretches coin pulses to an arcade-legal width;
- muxes an offset-binary analog axis for flight titles.

---
 rtl/arcade_input_mapper_if.sv | 29 ++
 rtl/arcade_input_mapper.sv | 200 ++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_mapper_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : arcade_input_mapper_if                                           |
// | Purpose  : ioctl download bus from hps_io into the input mapper.            |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface arcade_input_mapper_if;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (
        output ioctl_wr,
        output ioctl_index,
        output ioctl_addr,
        output ioctl_dout
    );

    modport slave (
        input ioctl_wr,
        input ioctl_index,
        input ioctl_addr,
        input ioctl_dout
    );
endinterface

`default_nettype wire

// File: rtl/arcade_input_mapper.sv
// +-----------------------------------------------------------------------------+
// | Module   : arcade_input_mapper                                              |
// | Purpose  : Config capture, joystick-to-tread mapping, coin stretching and   |
// |            analog axis mux for the vector-arcade cores.                     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module arcade_input_mapper #(
    parameter int NUM_PLAYERS       = 2,
    parameter int NUM_DSW           = 2,
    parameter int COIN_PULSE_CYCLES = 1_500_000,
    parameter int ANA_ON            = 48,
    parameter int ANA_HYST          = 16
) (
    input  logic                      clk_i,
    input  logic                      btnCpuReset,
    arcade_input_mapper_if.slave      ioctl,
    input  logic [16*NUM_PLAYERS-1:0] joy,
    input  logic [16*NUM_PLAYERS-1:0] joya,
    input  logic                      analog_en,
    input  logic                      stick_mode,
    input  logic                      axis_sel,
    output logic [7:0]                mod,
    output logic [8*NUM_DSW-1:0]      dsw,
    output logic [4*NUM_PLAYERS-1:0]  tread,
    output logic [NUM_PLAYERS-1:0]    fire,
    output logic [NUM_PLAYERS-1:0]    start,
    output logic [NUM_PLAYERS-1:0]    coin,
    output logic [7:0]                axis_out
);

    localparam int c_CNT_W = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(COIN_PULSE_CYCLES - 1);

    // Thresholds widened to 10 bits so signed 8-bit axes compare without wrap.
    localparam logic signed [9:0] c_ON      = 10'(ANA_ON);
    localparam logic signed [9:0] c_OFF     = 10'(ANA_ON - ANA_HYST);
    localparam logic signed [9:0] c_NEG_ON  = 10'(-ANA_ON);
    localparam logic signed [9:0] c_NEG_OFF = 10'(-(ANA_ON - ANA_HYST));

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_WAIT  = 2'd2
    } coin_state_t;

    logic [7:0] r_mod;
    logic [7:0] r_axis;

    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            r_mod  <= 8'hFF;
            r_axis <= 8'h80;
        end else begin
            if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd1)
                r_mod <= ioctl.ioctl_dout;
            r_axis <= axis_sel ? {~joya[15], joya[14:8]} : {~joya[7], joya[6:0]};
        end
    end

    assign mod      = r_mod;
    assign axis_out = r_axis;

    for (genvar k = 0; k < NUM_DSW; k++) begin : g_dsw
        logic [7:0] r_byte;

        always_ff @(posedge clk_i or negedge btnCpuReset) begin
            if (!btnCpuReset)
                r_byte <= 8'h00;
            else if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd254 &&
                     ioctl.ioctl_addr == 25'(k))
                r_byte <= ioctl.ioctl_dout;
        end

        assign dsw[8*k +: 8] = r_byte;
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic signed [9:0]  w_x;
        logic signed [9:0]  w_y;
        logic [3:0]         r_flag;
        logic [3:0]         w_dir;
        logic [3:0]         w_tread;
        logic [3:0]         r_tread;
        logic               r_fire;
        logic               r_start;
        logic               w_coin_in;
        logic               r_prev;
        logic               r_armed;
        logic               w_edge;
        coin_state_t        r_cs;
        coin_state_t        w_cs_nx;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nx;
        logic               w_unused_bits;

        assign w_unused_bits = ^joy[16*p+10 +: 6];

        assign w_x = {{2{joya[16*p+7]}},  joya[16*p +: 8]};
        assign w_y = {{2{joya[16*p+15]}}, joya[16*p+8 +: 8]};

        // Flag order {U, D, L, R} matches joy[3:0]; each holds until the release threshold.
        always_ff @(posedge clk_i or negedge btnCpuReset) begin
            if (!btnCpuReset || !analog_en) begin
                r_flag <= 4'b0000;
            end else begin
                r_flag[0] <= r_flag[0] ? (w_x >= c_OFF)     : (w_x >= c_ON);
                r_flag[1] <= r_flag[1] ? (w_x <= c_NEG_OFF) : (w_x <= c_NEG_ON);
                r_flag[2] <= r_flag[2] ? (w_y >= c_OFF)     : (w_y >= c_ON);
                r_flag[3] <= r_flag[3] ? (w_y <= c_NEG_OFF) : (w_y <= c_NEG_ON);
            end
        end

        assign w_dir = joy[16*p +: 4] | r_flag;

        always_comb begin
            w_tread = 4'b0000;
            if (stick_mode) begin
                w_tread = {w_dir[3] & ~w_dir[2], w_dir[2] & ~w_dir[3],
                           joy[16*p+9] & ~joy[16*p+8], joy[16*p+8] & ~joy[16*p+9]};
            end else begin
                case (w_dir)
                    4'b1000: w_tread = 4'b1010;
                    4'b0100: w_tread = 4'b0101;
                    4'b0001: w_tread = 4'b1001;
                    4'b0010: w_tread = 4'b0110;
                    4'b1010: w_tread = 4'b0010;
                    4'b1001: w_tread = 4'b1000;
                    4'b0101: w_tread = 4'b0100;
                    4'b0110: w_tread = 4'b0001;
                    default: w_tread = 4'b0000;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge btnCpuReset) begin
            if (!btnCpuReset) begin
                r_tread <= 4'b0000;
                r_fire  <= 1'b0;
                r_start <= 1'b0;
            end else begin
                r_tread <= w_tread;
                r_fire  <= joy[16*p+4] | joy[16*p+6];
                r_start <= joy[16*p+5];
            end
        end

        // r_armed blocks a button held through reset from looking like a fresh press.
        assign w_coin_in = joy[16*p+7];
        assign w_edge    = w_coin_in & ~r_prev & r_armed;

        always_comb begin
            w_cs_nx  = r_cs;
            w_cnt_nx = r_cnt;
            case (r_cs)
                COIN_IDLE: begin
                    if (w_edge) begin
                        w_cs_nx  = COIN_PULSE;
                        w_cnt_nx = c_CNT_LOAD;
                    end
                end
                COIN_PULSE: begin
                    if (r_cnt == '0)
                        w_cs_nx = w_coin_in ? COIN_WAIT : COIN_IDLE;
                    else
                        w_cnt_nx = r_cnt - 1'b1;
                end
                COIN_WAIT: begin
                    if (!w_coin_in)
                        w_cs_nx = COIN_IDLE;
                end
                default: w_cs_nx = COIN_IDLE;
            endcase
        end

        always_ff @(posedge clk_i or negedge btnCpuReset) begin
            if (!btnCpuReset) begin
                r_cs    <= COIN_IDLE;
                r_cnt   <= '0;
                r_prev  <= 1'b0;
                r_armed <= 1'b0;
            end else begin
                r_cs   <= w_cs_nx;
                r_cnt  <= w_cnt_nx;
                r_prev <= w_coin_in;
                if (!w_coin_in)
                    r_armed <= 1'b1;
            end
        end

        assign tread[4*p +: 4] = r_tread;
        assign fire[p]         = r_fire;
        assign start[p]        = r_start;
        assign coin[p]         = (r_cs == COIN_PULSE);
    end

endmodule

`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_arcade_input_mapper                                           |
// | Purpose  : Directed, table-driven self-checking bench for the input mapper. |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_arcade_input_mapper;

    localparam int c_NP = 2;
    localparam int c_ND = 2;
    localparam int c_CP = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] joy;
    logic [31:0] joya;
    logic        analog_en;
    logic        stick_mode;
    logic        axis_sel;
    logic [7:0]  mod;
    logic [15:0] dsw;
    logic [7:0]  tread;
    logic [1:0]  fire;
    logic [1:0]  start;
    logic [1:0]  coin;
    logic [7:0]  axis_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arcade_input_mapper_if bus ();

    arcade_input_mapper #(
        .NUM_PLAYERS       (c_NP),
        .NUM_DSW           (c_ND),
        .COIN_PULSE_CYCLES (c_CP),
        .ANA_ON            (48),
        .ANA_HYST          (16)
    ) dut (
        .clk_i       (clk),
        .btnCpuReset (rst_n),
        .ioctl       (bus),
        .joy         (joy),
        .joya        (joya),
        .analog_en   (analog_en),
        .stick_mode  (stick_mode),
        .axis_sel    (axis_sel),
        .mod         (mod),
        .dsw         (dsw),
        .tread       (tread),
        .fire        (fire),
        .start       (start),
        .coin        (coin),
        .axis_out    (axis_out)
    );

    typedef struct {
        logic [3:0] dir;
        logic [3:0] exp;
    } ss_vec_t;

    ss_vec_t ss_tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        bus.ioctl_wr    = 1'b1;
        bus.ioctl_index = idx;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = d;
        tick();
        bus.ioctl_wr    = 1'b0;
    endtask

    // Drives joy[7] from pat one bit per cycle and reports where coin[0] was high.
    task automatic coin_run(input logic [39:0] pat, output int cnt, output int first, output int last);
        cnt   = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 40; c++) begin
            joy[7] = pat[c];
            tick();
            if (coin[0]) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        joy[7] = 1'b0;
    endtask

    initial begin
        int cnt, first, last;

        ss_tbl[0]  = '{4'b0000, 4'b0000};
        ss_tbl[1]  = '{4'b0001, 4'b1001};
        ss_tbl[2]  = '{4'b0010, 4'b0110};
        ss_tbl[3]  = '{4'b0011, 4'b0000};
        ss_tbl[4]  = '{4'b0100, 4'b0101};
        ss_tbl[5]  = '{4'b0101, 4'b0100};
        ss_tbl[6]  = '{4'b0110, 4'b0001};
        ss_tbl[7]  = '{4'b0111, 4'b0000};
        ss_tbl[8]  = '{4'b1000, 4'b1010};
        ss_tbl[9]  = '{4'b1001, 4'b1000};
        ss_tbl[10] = '{4'b1010, 4'b0010};
        ss_tbl[11] = '{4'b1011, 4'b0000};
        ss_tbl[12] = '{4'b1100, 4'b0000};
        ss_tbl[13] = '{4'b1101, 4'b0000};
        ss_tbl[14] = '{4'b1110, 4'b0000};
        ss_tbl[15] = '{4'b1111, 4'b0000};

        rst_n           = 1'b0;
        joy             = '0;
        joya            = 32'h0000_1122;
        analog_en       = 1'b0;
        stick_mode      = 1'b0;
        axis_sel        = 1'b0;
        bus.ioctl_wr    = 1'b0;
        bus.ioctl_index = 8'd0;
        bus.ioctl_addr  = 25'd0;
        bus.ioctl_dout  = 8'd0;

        repeat (3) tick();
        chk("reset_mod",   32'(mod),      32'h0000_00FF);
        chk("reset_dsw",   32'(dsw),      32'h0000_0000);
        chk("reset_axis",  32'(axis_out), 32'h0000_0080);
        chk("reset_tread", 32'(tread),    32'h0000_0000);
        chk("reset_coin",  32'(coin),     32'h0000_0000);

        rst_n = 1'b1;
        joya  = '0;
        tick();

        ioctl_write(8'd1, 25'd0, 8'h02);
        chk("mod_write", 32'(mod), 32'h0000_0002);

        ioctl_write(8'd254, 25'd0, 8'hA5);
        ioctl_write(8'd254, 25'd1, 8'h3C);
        ioctl_write(8'd254, 25'd2, 8'hFF);
        ioctl_write(8'd254, 25'h100, 8'hEE);
        chk("dsw_capture", 32'(dsw), 32'h0000_3CA5);
        ioctl_write(8'd0, 25'd0, 8'h00);
        chk("dsw_other_index", 32'(dsw), 32'h0000_3CA5);
        chk("mod_unchanged",   32'(mod), 32'h0000_0002);

        // Single-stick sweep on both players, player 1 offset through the table.
        for (int i = 0; i < 16; i++) begin
            joy[3:0]   = ss_tbl[i].dir;
            joy[19:16] = ss_tbl[(i + 5) % 16].dir;
            tick();
            chk($sformatf("ss_p0_dir%0d", i), 32'(tread[3:0]), 32'(ss_tbl[i].exp));
            chk($sformatf("ss_p1_dir%0d", (i + 5) % 16), 32'(tread[7:4]), 32'(ss_tbl[(i + 5) % 16].exp));
        end
        joy = '0;
        tick();

        analog_en = 1'b1;
        joya[7:0] = 8'd0;  tick(); tick();
        joya[7:0] = 8'd16; tick(); tick();
        joya[7:0] = 8'd32; tick(); tick();
        joya[7:0] = 8'd47; tick(); tick();
        chk("ana_below_on", 32'(tread[3:0]), 32'h0);
        joya[7:0] = 8'd48; tick();
        chk("ana_latency", 32'(tread[3:0]), 32'h0);
        tick();
        chk("ana_r_set", 32'(tread[3:0]), 32'h9);
        joya[7:0] = 8'd33; tick(); tick();
        chk("ana_r_hold33", 32'(tread[3:0]), 32'h9);
        joya[7:0] = 8'd32; tick(); tick();
        chk("ana_r_hold32", 32'(tread[3:0]), 32'h9);
        joya[7:0] = 8'd31; tick();
        chk("ana_r_clear_lat", 32'(tread[3:0]), 32'h9);
        tick();
        chk("ana_r_clear", 32'(tread[3:0]), 32'h0);
        joya[7:0] = 8'hD0; tick(); tick();
        chk("ana_l_set", 32'(tread[3:0]), 32'h6);
        joya[7:0] = 8'hE0; tick(); tick();
        chk("ana_l_hold", 32'(tread[3:0]), 32'h6);
        joya[7:0] = 8'hE1; tick(); tick();
        chk("ana_l_clear", 32'(tread[3:0]), 32'h0);
        joya[15:0] = 16'h3000; tick(); tick();
        chk("ana_d_set", 32'(tread[3:0]), 32'h5);
        joya[15:0] = 16'hD000; tick(); tick(); tick();
        chk("ana_u_set", 32'(tread[3:0]), 32'hA);

        joya      = '0;
        analog_en = 1'b0;
        joya[7:0] = 8'd48; tick(); tick(); tick();
        chk("ana_disabled_48", 32'(tread[3:0]), 32'h0);
        joya[7:0] = 8'd127; tick(); tick();
        chk("ana_disabled_127", 32'(tread[3:0]), 32'h0);
        joya = '0;
        tick();

        stick_mode = 1'b1;
        joy[15:0] = 16'h0208; tick();
        chk("dual_u_rfw", 32'(tread[3:0]), 32'hA);
        joy[15:0] = 16'h0308; tick();
        chk("dual_r_both", 32'(tread[3:0]), 32'h8);
        joy[15:0] = 16'h0104; tick();
        chk("dual_d_rbk", 32'(tread[3:0]), 32'h5);
        joy[15:0] = 16'h000C; tick();
        chk("dual_ud", 32'(tread[3:0]), 32'h0);
        stick_mode = 1'b0;
        joy = '0;
        tick();

        joy[15:0]  = 16'h0010;
        joy[31:16] = 16'h0020;
        tick();
        chk("fire_start_a", 32'({start, fire}), 32'b1001);
        joy[15:0]  = 16'h0040;
        joy[31:16] = 16'h0000;
        tick();
        chk("fire_start2", 32'({start, fire}), 32'b0001);
        joy = '0;

        joya     = 32'h5500_8122;
        axis_sel = 1'b1;
        tick();
        chk("axis_y81", 32'(axis_out), 32'h01);
        joya[15:8] = 8'h7F; tick();
        chk("axis_y7f", 32'(axis_out), 32'hFF);
        axis_sel = 1'b0; tick();
        chk("axis_x22", 32'(axis_out), 32'hA2);
        joya = '0;
        tick();

        coin_run(40'h7, cnt, first, last);
        chk("coin_short_cnt",   32'(cnt),   32'd10);
        chk("coin_short_first", 32'(first), 32'd0);
        chk("coin_short_last",  32'(last),  32'd9);
        coin_run(40'h77, cnt, first, last);
        chk("coin_repress_cnt",  32'(cnt),  32'd10);
        chk("coin_repress_last", 32'(last), 32'd9);
        coin_run(40'hF_FFFF, cnt, first, last);
        chk("coin_held_cnt",  32'(cnt),  32'd10);
        chk("coin_held_last", 32'(last), 32'd9);
        coin_run(40'h7, cnt, first, last);
        chk("coin_after_rel_cnt",   32'(cnt),   32'd10);
        chk("coin_after_rel_first", 32'(first), 32'd0);

        joy[7] = 1'b1;
        tick();
        chk("coin_pre_reset", 32'(coin[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("coin_async_clear", 32'(coin[0]), 32'd0);
        chk("mod_reset_again",  32'(mod),     32'h0000_00FF);
        chk("dsw_reset_again",  32'(dsw),     32'h0000_0000);
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (coin[0]) cnt++;
        end
        chk("coin_held_thru_reset", 32'(cnt), 32'd0);
        joy[7] = 1'b0;
        tick();
        coin_run(40'h7, cnt, first, last);
        chk("coin_post_reset_cnt", 32'(cnt), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
